// File: rtl/eth_pcs_tx_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : eth_pcs_tx_scrambler
// Purpose  : 64b/66b TX scrambler. It takes whole 66-bit blocks from the
//            encoder over a valid/ready handshake and splits each block into
//            two 32-bit transfers. The payload is scrambled with the
//            self-synchronous polynomial 1 + x^39 + x^58, and the sync header
//            passes through unscrambled. Transfers are issued in lockstep
//            with the gearbox clock enable and transfer phase. When no block
//            is ready, an idle block is inserted.
// Ports    : i_clk, i_reset            clock, synchronous active-high reset
//            i_blk_valid/o_blk_ready   encoder handshake
//            i_blk_sync, i_blk_data    block header / payload (bit 0 first)
//            i_bypass                  1 = pass payload unscrambled
//            i_gb_clk_en, i_gb_trans_cnt  gearbox consume strobe / phase
//            o_sync_data, o_scr_data   header and data word to gearbox
//            o_underflow, o_align_err  one-cycle event pulses
// Revision : 1.0 - initial release
// ============================================================================
module eth_pcs_tx_scrambler #(
    parameter int unsigned         W_DATA    = 32,
    parameter int unsigned         W_SYNC    = 2,
    parameter int unsigned         W_BLK     = 64,
    parameter logic [57:0]         SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF,
    parameter logic [W_SYNC-1:0]   IDLE_SYNC = 2'b01,
    parameter logic [W_BLK-1:0]    IDLE_BLK  = 64'h0000_0000_0000_001E
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_blk_valid,
    output logic                o_blk_ready,
    input  logic [W_SYNC-1:0]   i_blk_sync,
    input  logic [W_BLK-1:0]    i_blk_data,
    input  logic                i_bypass,
    input  logic                i_gb_clk_en,
    input  logic                i_gb_trans_cnt,
    output logic [W_SYNC-1:0]   o_sync_data,
    output logic [W_DATA-1:0]   o_scr_data,
    output logic                o_underflow,
    output logic                o_align_err
);

    localparam int unsigned c_W_HOLD = W_SYNC + W_BLK;

    // Skid register and output-side state
    logic [c_W_HOLD-1:0] hold_q,       hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic [W_DATA-1:0]   cur_hi_q,     cur_hi_d;
    logic                half_q,       half_d;
    logic [57:0]         scr_q,        scr_d;
    logic [W_SYNC-1:0]   sync_q,       sync_d;
    logic [W_DATA-1:0]   data_q,       data_d;
    logic                underflow_q,  underflow_d;
    logic                align_err_q,  align_err_d;

    logic                w_load_half0;
    logic                w_accept;
    logic [c_W_HOLD-1:0] w_blk;
    logic [W_DATA-1:0]   w_word;
    logic [W_DATA-1:0]   w_word_scr;
    logic [57:0]         w_scr_next;

    // The gearbox phase decides which half is loaded. A mismatch with
    // half_q is reported, but the gearbox phase is always followed.
    assign w_load_half0 = i_gb_clk_en & i_gb_trans_cnt;
    assign o_blk_ready  = ~hold_valid_q | w_load_half0;
    assign w_accept     = i_blk_valid & o_blk_ready;

    // Block entering the output: held block if present, else an idle block
    assign w_blk  = hold_valid_q ? hold_q : {IDLE_SYNC, IDLE_BLK};
    assign w_word = i_gb_trans_cnt ? w_blk[W_DATA-1:0] : cur_hi_q;

    // Bit-serial scrambler unrolled over one word. Each output bit is fed back
    // before the next bit is computed. Bit 0 is the first bit on the line.
    always_comb begin
        w_scr_next = scr_q;
        w_word_scr = w_word;
        if (!i_bypass) begin
            for (int i = 0; i < int'(W_DATA); i++) begin
                w_word_scr[i] = w_word[i] ^ w_scr_next[38] ^ w_scr_next[57];
                w_scr_next    = {w_scr_next[56:0], w_word_scr[i]};
            end
        end
    end

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        cur_hi_d     = cur_hi_q;
        half_d       = half_q;
        scr_d        = scr_q;
        sync_d       = sync_q;
        data_d       = data_q;
        underflow_d  = 1'b0;
        align_err_d  = 1'b0;

        if (i_gb_clk_en) begin
            align_err_d = (half_q != i_gb_trans_cnt);
            data_d      = w_word_scr;
            scr_d       = w_scr_next;
            if (i_gb_trans_cnt) begin
                sync_d       = w_blk[c_W_HOLD-1 -: W_SYNC];
                cur_hi_d     = w_blk[W_BLK-1 -: W_DATA];
                half_d       = 1'b0;
                underflow_d  = ~hold_valid_q;
                hold_valid_d = 1'b0;
            end else begin
                half_d = 1'b1;
            end
        end

        // A refill in the same cycle as the drain keeps the skid full
        if (w_accept) begin
            hold_d       = {i_blk_sync, i_blk_data};
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            cur_hi_q     <= IDLE_BLK[W_BLK-1 -: W_DATA];
            half_q       <= 1'b0;
            scr_q        <= SCR_SEED;
            sync_q       <= IDLE_SYNC;
            data_q       <= IDLE_BLK[W_DATA-1:0];
            underflow_q  <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            cur_hi_q     <= cur_hi_d;
            half_q       <= half_d;
            scr_q        <= scr_d;
            sync_q       <= sync_d;
            data_q       <= data_d;
            underflow_q  <= underflow_d;
            align_err_q  <= align_err_d;
        end
    end

    assign o_sync_data = sync_q;
    assign o_scr_data  = data_q;
    assign o_underflow = underflow_q;
    assign o_align_err = align_err_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_pcs_tx_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_pcs_tx_scrambler
// Purpose  : Self-checking bench for eth_pcs_tx_scrambler. A behavioural
//            model built from a block queue and a line-bit history predicts
//            ready and all outputs on every cycle. Literal values pin the
//            model at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_pcs_tx_scrambler;

    localparam logic [1:0]  IDLE_SYNC = 2'b01;
    localparam logic [63:0] IDLE_BLK  = 64'h0000_0000_0000_001E;

    logic        clk = 1'b0;
    logic        rst, v, byp, en, tc;
    logic [1:0]  bsync;
    logic [63:0] bdata;
    logic        ready, uf, ae;
    logic [1:0]  sync_o;
    logic [31:0] data_o;

    always #5 clk = ~clk;

    eth_pcs_tx_scrambler dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_blk_valid    (v),
        .o_blk_ready    (ready),
        .i_blk_sync     (bsync),
        .i_blk_data     (bdata),
        .i_bypass       (byp),
        .i_gb_clk_en    (en),
        .i_gb_trans_cnt (tc),
        .o_sync_data    (sync_o),
        .o_scr_data     (data_o),
        .o_underflow    (uf),
        .o_align_err    (ae)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [65:0] m_pend[$];    // blocks accepted but not yet on the line
    bit          m_hist[$];    // transmitted scrambled bits, index 0 = newest
    logic [31:0] m_hi, m_data;
    logic [1:0]  m_sync;
    bit          m_phase, m_uf, m_ae;
    bit          gb_tc;
    int          gb_cnt;

    function automatic void m_reset();
        m_pend.delete();
        m_hist.delete();
        repeat (58) m_hist.push_back(1'b1);
        m_hi    = IDLE_BLK[63:32];
        m_data  = IDLE_BLK[31:0];
        m_sync  = IDLE_SYNC;
        m_phase = 1'b0;
        m_uf    = 1'b0;
        m_ae    = 1'b0;
    endfunction

    // Scramble one word: line bit = data ^ bit sent 39 ago ^ bit sent 58 ago
    function automatic logic [31:0] m_scr(input logic [31:0] d, input bit b);
        logic [31:0] r;
        bit o;
        if (b) return d;
        for (int i = 0; i < 32; i++) begin
            o    = d[i] ^ m_hist[38] ^ m_hist[57];
            r[i] = o;
            m_hist.push_front(o);
            void'(m_hist.pop_back());
        end
        return r;
    endfunction

    // One clock: drive inputs, check ready, advance model, check outputs.
    task automatic cyc(input bit r, input bit vv, input logic [65:0] blk,
                       input bit bp, input bit e, input bit slip, output bit acc);
        bit t, exp_rdy;
        logic [65:0] b;
        t     = gb_tc ^ slip;
        rst   = r;
        v     = vv;
        bsync = blk[65:64];
        bdata = blk[63:0];
        byp   = bp;
        en    = e;
        tc    = t;
        #1;
        exp_rdy = (m_pend.size() == 0) || (e && t);
        chk("ready", ready, exp_rdy);
        acc = vv && exp_rdy && !r;
        if (r) begin
            m_reset();
            gb_tc = 1'b0;
        end else begin
            m_uf = 1'b0;
            m_ae = 1'b0;
            if (e) begin
                m_ae = (m_phase != t);
                if (!t) begin
                    m_data  = m_scr(m_hi, bp);
                    m_phase = 1'b1;
                end else begin
                    if (m_pend.size() != 0) b = m_pend.pop_front();
                    else begin
                        b    = {IDLE_SYNC, IDLE_BLK};
                        m_uf = 1'b1;
                    end
                    m_sync  = b[65:64];
                    m_data  = m_scr(b[31:0], bp);
                    m_hi    = b[63:32];
                    m_phase = 1'b0;
                end
                gb_tc = !t;
            end
            if (acc) m_pend.push_back(blk);
        end
        @(posedge clk);
        #1;
        chk("sync", sync_o, m_sync);
        chk("data", data_o, m_data);
        chk("underflow", uf, m_uf);
        chk("align_err", ae, m_ae);
    endtask

    function automatic bit gb_step();
        bit e;
        e      = (gb_cnt != 32);
        gb_cnt = (gb_cnt + 1) % 33;
        return e;
    endfunction

    initial begin
        bit acc, e;
        int nuf, nacc, guard;
        logic [65:0] blk;

        rst = 1'b1; v = 1'b0; byp = 1'b0; en = 1'b0; tc = 1'b0;
        bsync = 2'b00; bdata = '0;
        gb_tc = 1'b0; gb_cnt = 0;
        m_reset();
        @(posedge clk);
        cyc(1, 0, '0, 0, 1, 0, acc);

        // Reset state
        chk("rst_sync", sync_o, 2'b01);
        chk("rst_data", data_o, 32'h0000_001E);
        chk("rst_ready", ready, 1'b1);
        chk("rst_uf", uf, 1'b0);
        chk("rst_ae", ae, 1'b0);

        // No input: idle insertion every second consume
        nuf = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, '0, 0, 1, 0, acc);
            nuf += int'(uf);
            if (k == 0) chk("idle_hi_word", data_o, 32'h0000_0000);
            if (k == 1) begin
                chk("idle_lo_word", data_o, 32'h03FF_FF9E);
                chk("idle_sync", sync_o, 2'b01);
            end
        end
        chk("idle_uf_count", nuf, 5);

        // Back-to-back stream with gearbox pause pattern
        nuf = 0; nacc = 0;
        for (int k = 0; k < 120; k++) begin
            e   = gb_step();
            blk = {2'b10, 64'h0123_4567_89AB_CDEF + 64'(nacc)};
            cyc(0, 1, blk, 0, e, 0, acc);
            if (acc) nacc++;
            nuf += int'(uf);
        end
        chk("b2b_no_underflow", nuf, 0);
        chk("b2b_rate_ok", (nacc >= 55) ? 1 : 0, 1);

        // Backpressure: gearbox paused with encoder valid
        cyc(0, 0, '0, 0, 1, 0, acc);
        cyc(0, 0, '0, 0, 1, 0, acc);
        nacc = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, {2'b10, 64'hDEAD_BEEF_0000_0000 + 64'(k)}, 0, 0, 0, acc);
            if (acc) nacc++;
        end
        chk("bp_accepts", nacc, 1);
        chk("bp_ready_low", ready, 1'b0);

        // Bypass one block
        guard = 0;
        while (!(m_pend.size() == 0 && gb_tc == 1'b0) && guard < 8) begin
            cyc(0, 0, '0, 0, 1, 0, acc);
            guard++;
        end
        cyc(0, 1, {2'b10, 64'hFFFF_0000_AAAA_5555}, 0, 1, 0, acc);
        chk("byp_accept", acc, 1'b1);
        cyc(0, 0, '0, 1, 1, 0, acc);
        chk("byp_lo", data_o, 32'hAAAA_5555);
        chk("byp_sync", sync_o, 2'b10);
        cyc(0, 0, '0, 1, 1, 0, acc);
        chk("byp_hi", data_o, 32'hFFFF_0000);

        // Phase slip
        cyc(0, 0, '0, 0, 1, 0, acc);
        chk("pre_slip_ae", ae, 1'b0);
        cyc(0, 0, '0, 0, 1, 1, acc);
        chk("slip_ae", ae, 1'b1);
        cyc(0, 0, '0, 0, 1, 0, acc);
        chk("post_slip_ae", ae, 1'b0);

        // Randomized traffic
        gb_cnt = 0;
        for (int k = 0; k < 600; k++) begin
            e   = gb_step();
            blk = {($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, $urandom(), $urandom()};
            cyc(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, blk,
                ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, e,
                ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, acc);
        end

        // Reset mid-block
        cyc(0, 1, {2'b10, 64'h5555_AAAA_1234_5678}, 0, 1, 0, acc);
        cyc(1, 1, {2'b10, 64'h1111_2222_3333_4444}, 0, 1, 0, acc);
        cyc(1, 0, '0, 0, 1, 0, acc);
        chk("rst2_sync", sync_o, 2'b01);
        chk("rst2_data", data_o, 32'h0000_001E);
        chk("rst2_uf", uf, 1'b0);
        chk("rst2_ae", ae, 1'b0);
        chk("rst2_ready", ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_pcs_tx_scrambler.md
# eth_pcs_tx_scrambler

TX-path stage between the 64b/66b encoder and `eth_pcs_tx_gearbox`. It accepts whole 66-bit blocks (2-bit sync header + 64-bit payload) from the encoder over a valid/ready handshake and splits each into two 32-bit transfers. It scrambles the payload with the self-synchronous polynomial 1 + x^39 + x^58 and presents header and data words to the gearbox in lockstep with the gearbox's `o_clk_en` / `o_trans_cnt`. If no block is available when one is needed, it inserts an idle block.

## Interface
- `W_DATA`, 32: gearbox transfer width (bits per transfer).
- `W_SYNC`, 2: sync header width.
- `W_BLK`, 64: block payload width; equals 2*W_DATA.
- `SCR_SEED`, 58'h3FF_FFFF_FFFF_FFFF: scrambler state after reset.
- `IDLE_SYNC`, 2'b01: header of an inserted idle block.
- `IDLE_BLK`, 64'h0000_0000_0000_001E: payload of an inserted idle block (type 0x1E, all /I/).

Ports:
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_blk_valid`, in, 1: encoder block valid.
- `o_blk_ready`, out, 1: block accepted when valid && ready.
- `i_blk_sync`, in, W_SYNC: block sync header.
- `i_blk_data`, in, W_BLK: block payload. Bit 0 is transmitted first.
- `i_bypass`, in, 1: 1 disables scrambling.
- `i_gb_clk_en`, in, 1: gearbox `o_clk_en`.
- `i_gb_trans_cnt`, in, 1: gearbox `o_trans_cnt`.
- `o_sync_data`, out, W_SYNC: to gearbox `i_sync_data`.
- `o_scr_data`, out, W_DATA: to gearbox `i_scr_data`.
- `o_underflow`, out, 1: one-cycle pulse when an idle block is inserted.
- `o_align_err`, out, 1: one-cycle pulse on phase mismatch with the gearbox.

## Operation
- **Storage**
  - `hold`: 66 bits plus `hold_valid`; a one-block skid register.
  - `cur_hi`: 32 bits, the upper half of the block currently on the output.
  - `q_half`: phase of the word currently on the output (0 = low half + header, 1 = high half).
  - Scrambler state: 58 bits.
- **Consume event:** `i_gb_clk_en` == 1. The output registers update at the following edge. When `i_gb_clk_en` == 0, all output registers, `q_half` and the scrambler state hold.
- **Consume with `q_half` == 0:**
  - Output loads `scr(cur_hi)`. `o_sync_data` holds. `q_half` becomes 1.
- **Consume with `q_half` == 1 (load_half0):**
  - If `hold_valid`: the block is taken from `hold`, and `hold_valid` clears unless refilled in the same cycle.
  - Otherwise: the block is {IDLE_SYNC, IDLE_BLK}, and `o_underflow` pulses.
  - Output loads `sync` and `scr(blk[31:0])`. `cur_hi` = `blk[63:32]`. `q_half` becomes 0.
- **Handshake:**
  - `o_blk_ready` = !`hold_valid` || load_half0 (combinational).
  - Accept with load_half0 in the same cycle: the new block refills `hold` and `hold_valid` stays 1.
  - `i_blk_*` are ignored when not accepted.
- **Scrambling, per 32-bit word, bit i = 0..31 in order:**
  - out[i] = d[i] ^ S[38] ^ S[57], where S[0] is the most recent scrambled bit.
  - Each out[i] is shifted into S before bit i+1 is computed.
  - The header is never scrambled. Inserted idle blocks are scrambled identically.
- **Bypass:** with `i_bypass` = 1, out = d and S holds. `i_bypass` is sampled per word at load time.
- **Alignment check:** on each consume, if `q_half` != `i_gb_trans_cnt`, `o_align_err` pulses the next cycle and `q_half` is forced to follow `i_gb_trans_cnt`. The word loaded is the half opposite the gearbox's phase.

## Timing
- **Reset values:**
  - `o_sync_data` = IDLE_SYNC; `o_scr_data` = IDLE_BLK[31:0] unscrambled.
  - `cur_hi` = IDLE_BLK[63:32]; `q_half` = 0; S = SCR_SEED.
  - `hold_valid` = 0, so `o_blk_ready` = 1 in the first cycle after reset.
  - `o_underflow` = `o_align_err` = 0.
  - Reset mid-block discards `hold` and `cur_hi`, with no pulses.
- **Latency:** a block accepted at cycle t appears as the half-0 word no earlier than t+2. It waits further if the gearbox is mid-block or paused.
- **Gearbox pause:** the gearbox drops `i_gb_clk_en` for 1 cycle in 33. During that cycle the outputs are stable, and `o_blk_ready` = !`hold_valid`.
- **Sustained rate:** one block per two consume cycles. With `hold`, the encoder never stalls the line when it presents a block within 1 cycle of ready.

## Test plan
- **Reset:** assert `i_reset` for 2 cycles → `o_sync_data` = 2'b01, `o_scr_data` = 32'h0000_001E, `o_blk_ready` = 1, no pulses.
- **No input:** keep `i_gb_clk_en` = 1 and `i_blk_valid` = 0 for 10 cycles → `o_underflow` pulses every 2nd cycle. Scrambled idle words match a reference LFSR model seeded with SCR_SEED.
- **Back-to-back blocks:** stream blocks with payloads 64'h0123_4567_89AB_CDEF + n, with the 33-cycle `i_gb_clk_en` pattern from a gearbox model → descrambled output equals the input in order, no underflow, outputs frozen on every pause cycle.
- **Backpressure:** hold `i_gb_clk_en` = 0 for 5 cycles with `i_blk_valid` = 1 → exactly one block accepted, then `o_blk_ready` = 0 until the next load_half0.
- **Bypass:** set `i_bypass` = 1 for one block 64'hFFFF_0000_AAAA_5555 → `o_scr_data` = 32'hAAAA_5555 then 32'hFFFF_0000, and S unchanged across the block.
- **Phase slip:** drive `i_gb_trans_cnt` inverted for one consume → `o_align_err` pulses once, and the next consume shows no error.
